// File: rtl/abc_pkg.sv
// Shared types and default sizing for the abc operation scheduler.
package abc_pkg;

  localparam int unsigned AbcDw      = 12;
  localparam int unsigned AbcRw      = 2 * AbcDw + 1;
  localparam int unsigned AbcLatency = 5;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StIdle  = 2'd2
  } state_e;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage

// File: rtl/abc_sched_tagpipe.sv
// Shift register of {valid, requester id} tags running alongside the external abc datapath.
module abc_sched_tagpipe
  import abc_pkg::*;
#(
  parameter int unsigned Depth = AbcLatency
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  tag_t tag_i,
  output tag_t tail_o,
  output logic any_valid_o
);

  tag_t stage_q [Depth];
  tag_t stage_d [Depth];

  always_comb begin
    stage_d[0] = tag_i;
    for (int i = 1; i < Depth; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < Depth; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  always_comb begin
    any_valid_o = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      any_valid_o = any_valid_o | stage_q[i].valid;
    end
  end

  assign tail_o = stage_q[Depth-1];

endmodule

// File: rtl/abc_sched.sv
// Two-requester round-robin scheduler for an external (a+b)*c datapath with pause/drain.
// Optional acceptance counters stat0/stat1 are built when ABC_SCHED_STATS_EN is defined.
module abc_sched
  import abc_pkg::*;
#(
  parameter int unsigned LATENCY = AbcLatency,
  parameter int unsigned DW      = AbcDw
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic            req1_valid,
  output logic            req0_ready,
  output logic            req1_ready,
  input  logic [DW-1:0]   req0_a,
  input  logic [DW-1:0]   req0_b,
  input  logic [DW-1:0]   req0_c,
  input  logic [DW-1:0]   req1_a,
  input  logic [DW-1:0]   req1_b,
  input  logic [DW-1:0]   req1_c,
  output logic            resp0_valid,
  output logic            resp1_valid,
  output logic [2*DW:0]   resp0_y,
  output logic [2*DW:0]   resp1_y,
  output logic            dp_ce,
  output logic [DW-1:0]   dp_a,
  output logic [DW-1:0]   dp_b,
  output logic [DW-1:0]   dp_c,
  input  logic [2*DW:0]   dp_y,
  input  logic            pause,
`ifdef ABC_SCHED_STATS_EN
  output logic [15:0]     stat0,
  output logic [15:0]     stat1,
`endif
  output logic            idle
);

  state_e state_q, state_d;
  logic   ptr_q, ptr_d;
  logic   accept0, accept1;
  logic   busy, pipe_any;
  tag_t   iss_d, iss_q, tail;

  logic [DW-1:0] dp_a_q, dp_b_q, dp_c_q;
  logic          dp_ce_q;
  logic          resp0_valid_q, resp1_valid_q;
  logic [2*DW:0] resp0_y_q, resp1_y_q;

  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state_q)
      StRun: begin
        if (req0_valid && req1_valid) begin
          req0_ready = ~ptr_q;
          req1_ready = ptr_q;
        end else begin
          req0_ready = req0_valid;
          req1_ready = req1_valid;
        end
        if (pause) state_d = StDrain;
      end
      StDrain: begin
        if (!busy) state_d = StIdle;
      end
      StIdle: begin
        if (!pause) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  assign accept0 = req0_valid & req0_ready;
  assign accept1 = req1_valid & req1_ready;

  // Pointer moves to the requester that was not just served.
  assign ptr_d = accept0 ? 1'b1 : (accept1 ? 1'b0 : ptr_q);

  assign iss_d = '{valid: accept0 | accept1, id: accept1};
  assign busy  = iss_q.valid | pipe_any;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
      ptr_q   <= 1'b0;
      iss_q   <= '0;
      dp_ce_q <= 1'b0;
      dp_a_q  <= '0;
      dp_b_q  <= '0;
      dp_c_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      iss_q   <= iss_d;
      dp_ce_q <= 1'b1;
      if (accept0) begin
        dp_a_q <= req0_a;
        dp_b_q <= req0_b;
        dp_c_q <= req0_c;
      end else if (accept1) begin
        dp_a_q <= req1_a;
        dp_b_q <= req1_b;
        dp_c_q <= req1_c;
      end
    end
  end

  // Issue register above aligns with dp_a/b/c; this pipe then matches the datapath depth.
  abc_sched_tagpipe #(
    .Depth (LATENCY)
  ) u_tagpipe (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .tag_i       (iss_q),
    .tail_o      (tail),
    .any_valid_o (pipe_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_y_q     <= '0;
      resp1_y_q     <= '0;
    end else begin
      resp0_valid_q <= tail.valid & ~tail.id;
      resp1_valid_q <= tail.valid & tail.id;
      if (tail.valid && !tail.id) resp0_y_q <= dp_y;
      if (tail.valid && tail.id)  resp1_y_q <= dp_y;
    end
  end

`ifdef ABC_SCHED_STATS_EN
  logic [15:0] stat0_q, stat1_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat0_q <= '0;
      stat1_q <= '0;
    end else begin
      if (accept0 && stat0_q != 16'hffff) stat0_q <= stat0_q + 16'd1;
      if (accept1 && stat1_q != 16'hffff) stat1_q <= stat1_q + 16'd1;
    end
  end

  assign stat0 = stat0_q;
  assign stat1 = stat1_q;
`endif

  assign dp_ce       = dp_ce_q;
  assign dp_a        = dp_a_q;
  assign dp_b        = dp_b_q;
  assign dp_c        = dp_c_q;
  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign resp0_y     = resp0_y_q;
  assign resp1_y     = resp1_y_q;
  assign idle        = (state_q == StIdle);

endmodule

// File: tb/tb_abc_sched.sv
// Directed bench for abc_sched with a behavioural 5-stage (a+b)*c datapath.
module tb_abc_sched;

  localparam int DW = 12;
  localparam int RW = 2 * DW + 1;
  localparam int LAT = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic req0_ready, req1_ready;
  logic signed [DW-1:0] req0_a = '0, req0_b = '0, req0_c = '0;
  logic signed [DW-1:0] req1_a = '0, req1_b = '0, req1_c = '0;
  logic resp0_valid, resp1_valid;
  logic signed [RW-1:0] resp0_y, resp1_y, dp_y;
  logic dp_ce;
  logic signed [DW-1:0] dp_a, dp_b, dp_c;
  logic pause = 1'b0;
  logic idle;
`ifdef ABC_SCHED_STATS_EN
  logic [15:0] stat0, stat1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic signed [RW-1:0] dps [LAT];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dp_ce) begin
      dps[0] <= RW'((int'(dp_a) + int'(dp_b)) * int'(dp_c));
      for (int i = 1; i < LAT; i++) dps[i] <= dps[i-1];
    end
  end
  assign dp_y = dps[LAT-1];

  abc_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req1_valid  (req1_valid),
    .req0_ready  (req0_ready),
    .req1_ready  (req1_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_c      (req0_c),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_c      (req1_c),
    .resp0_valid (resp0_valid),
    .resp1_valid (resp1_valid),
    .resp0_y     (resp0_y),
    .resp1_y     (resp1_y),
    .dp_ce       (dp_ce),
    .dp_a        (dp_a),
    .dp_b        (dp_b),
    .dp_c        (dp_c),
    .dp_y        (dp_y),
    .pause       (pause),
`ifdef ABC_SCHED_STATS_EN
    .stat0       (stat0),
    .stat1       (stat1),
`endif
    .idle        (idle)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_cmp++;
    if ({dp_ce, resp0_valid, resp1_valid, idle} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctl: got %b want 0000", {dp_ce, resp0_valid, resp1_valid, idle});
    end
    n_cmp++;
    if ({dp_a, dp_b, dp_c} !== '0) begin
      n_err++;
      $display("FAIL reset_dp: got %0d/%0d/%0d want 0/0/0", dp_a, dp_b, dp_c);
    end
    n_cmp++;
    if ({resp0_y, resp1_y} !== '0) begin
      n_err++;
      $display("FAIL reset_y: got %0d/%0d want 0/0", resp0_y, resp1_y);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({dp_ce, idle} !== 2'b10) begin
      n_err++;
      $display("FAIL release_ce: got %b want 10", {dp_ce, idle});
    end
  endtask

  task automatic test_lone_req1();
    int first = -1;
    int n1 = 0;
    int n0 = 0;
    req1_a = -12'sd2048; req1_b = -12'sd2048; req1_c = -12'sd2048;
    req1_valid = 1'b1;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL lone1_grant: got %b want 01", {req0_ready, req1_ready});
    end
    step();
    req1_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (resp1_valid) begin
        n1++;
        if (first < 0) first = k;
      end
      if (resp0_valid) n0++;
    end
    n_cmp++;
    if (first !== 6 || n1 !== 1) begin
      n_err++;
      $display("FAIL lone1_latency: got first=%0d count=%0d want 6/1", first, n1);
    end
    n_cmp++;
    if (resp1_y !== 25'sd8388608) begin
      n_err++;
      $display("FAIL lone1_y: got %0d want 8388608", resp1_y);
    end
    n_cmp++;
    if (n0 !== 0) begin
      n_err++;
      $display("FAIL lone1_other: got %0d resp0 strobes want 0", n0);
    end
  endtask

  task automatic test_alternate();
    logic e0, e1;
    req0_a = -12'sd4;   req0_b = 12'sd26;   req0_c = 12'sd23;
    req1_a = 12'sd2047; req1_b = 12'sd2047; req1_c = -12'sd2048;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      e0 = (i % 2 == 0);
      e1 = (i % 2 == 1);
      n_cmp++;
      if ({req0_ready, req1_ready} !== {e0, e1}) begin
        n_err++;
        $display("FAIL alt_grant%0d: got %b want %b", i, {req0_ready, req1_ready}, {e0, e1});
      end
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int j = 4; j <= 11; j++) begin
      step();
      e0 = (j == 6 || j == 8);
      e1 = (j == 7 || j == 9);
      n_cmp++;
      if ({resp0_valid, resp1_valid} !== {e0, e1}) begin
        n_err++;
        $display("FAIL alt_strobe%0d: got %b want %b", j, {resp0_valid, resp1_valid}, {e0, e1});
      end
      if (e0 && resp0_y !== 25'sd506) begin
        n_err++;
        $display("FAIL alt_y0_%0d: got %0d want 506", j, resp0_y);
      end
      if (e1 && resp1_y !== -25'sd8384512) begin
        n_err++;
        $display("FAIL alt_y1_%0d: got %0d want -8384512", j, resp1_y);
      end
    end
    n_cmp++;
    if (resp0_y !== 25'sd506) begin
      n_err++;
      $display("FAIL alt_hold0: got %0d want 506", resp0_y);
    end
  endtask

  task automatic test_single();
    int first = -1;
    int n0 = 0;
    int n1 = 0;
    req0_a = 12'sd4; req0_b = 12'sd6; req0_c = 12'sd7;
    req0_valid = 1'b1;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL single_grant: got %b want 10", {req0_ready, req1_ready});
    end
    step();
    req0_valid = 1'b0;
    n_cmp++;
    if (dp_a !== 12'sd4 || dp_b !== 12'sd6 || dp_c !== 12'sd7) begin
      n_err++;
      $display("FAIL single_dp: got %0d/%0d/%0d want 4/6/7", dp_a, dp_b, dp_c);
    end
    for (int k = 1; k <= 10; k++) begin
      step();
      if (resp0_valid) begin
        n0++;
        if (first < 0) first = k;
      end
      if (resp1_valid) n1++;
    end
    n_cmp++;
    if (first !== 6 || n0 !== 1) begin
      n_err++;
      $display("FAIL single_latency: got first=%0d count=%0d want 6/1", first, n0);
    end
    n_cmp++;
    if (resp0_y !== 25'sd70 || n1 !== 0) begin
      n_err++;
      $display("FAIL single_y: got y=%0d resp1=%0d want 70/0", resp0_y, n1);
    end
  endtask

  task automatic test_drain();
    logic signed [DW-1:0] ta [3];
    logic signed [DW-1:0] tb [3];
    logic signed [DW-1:0] tc [3];
    logic signed [RW-1:0] ty [3];
    int ri = 0;
    int n1 = 0;
    ta[0] = 12'sd1;  tb[0] = 12'sd2; tc[0] = 12'sd3;   ty[0] = 25'sd9;
    ta[1] = 12'sd5;  tb[1] = 12'sd5; tc[1] = -12'sd3;  ty[1] = -25'sd30;
    ta[2] = -12'sd7; tb[2] = 12'sd0; tc[2] = 12'sd100; ty[2] = -25'sd700;
    for (int i = 0; i < 3; i++) begin
      req0_a = ta[i]; req0_b = tb[i]; req0_c = tc[i];
      req0_valid = 1'b1;
      if (i == 2) pause = 1'b1;
      #1;
      n_cmp++;
      if (req0_ready !== 1'b1) begin
        n_err++;
        $display("FAIL drain_issue%0d: got ready %b want 1", i, req0_ready);
      end
      step();
    end
    req1_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_cmp++;
      if ({req0_ready, req1_ready, idle} !== {2'b00, (k >= 7)}) begin
        n_err++;
        $display("FAIL drain_cyc%0d: got rdy/idle %b want %b", k, {req0_ready, req1_ready, idle},
                 {2'b00, (k >= 7)});
      end
      if (resp0_valid) begin
        if (ri > 2 || resp0_y !== ty[ri]) begin
          n_err++;
          $display("FAIL drain_resp%0d: got %0d at cycle %0d", ri, resp0_y, k);
        end
        ri++;
      end
      if (resp1_valid) n1++;
    end
    n_cmp++;
    if (ri !== 3 || n1 !== 0) begin
      n_err++;
      $display("FAIL drain_count: got %0d/%0d responses want 3/0", ri, n1);
    end
    pause = 1'b0;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready, idle} !== 3'b001) begin
      n_err++;
      $display("FAIL idle_hold: got %b want 001", {req0_ready, req1_ready, idle});
    end
    step();
    req1_a = 12'sd1; req1_b = 12'sd1; req1_c = 12'sd1;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready, idle} !== 3'b010) begin
      n_err++;
      $display("FAIL resume_grant: got %b want 010", {req0_ready, req1_ready, idle});
    end
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n1 = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (resp1_valid) n1++;
    end
    n_cmp++;
    if (n1 !== 1 || resp1_y !== 25'sd2) begin
      n_err++;
      $display("FAIL resume_resp: got %0d strobes y=%0d want 1/2", n1, resp1_y);
    end
  endtask

  task automatic test_reset_midflight();
    int nr = 0;
    req0_a = 12'sd4; req0_b = 12'sd6; req0_c = 12'sd7;
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    n_cmp++;
    if ({dp_ce, resp0_valid, resp1_valid, idle} !== 4'b0000 || {dp_a, dp_b, dp_c} !== '0) begin
      n_err++;
      $display("FAIL mid_reset_ctl: got %b dp=%0d want 0000 dp=0",
               {dp_ce, resp0_valid, resp1_valid, idle}, dp_a);
    end
    n_cmp++;
    if ({resp0_y, resp1_y} !== '0) begin
      n_err++;
      $display("FAIL mid_reset_y: got %0d/%0d want 0/0", resp0_y, resp1_y);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (resp0_valid || resp1_valid) nr++;
    end
    n_cmp++;
    if (nr !== 0 || resp0_y !== '0) begin
      n_err++;
      $display("FAIL mid_reset_ghost: got %0d strobes y=%0d want 0/0", nr, resp0_y);
    end
  endtask

`ifdef ABC_SCHED_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++;
    if ({stat0, stat1} !== 32'd0) begin
      n_err++;
      $display("FAIL stats_clear: got %0d/%0d want 0/0", stat0, stat1);
    end
    req0_a = 12'sd1; req0_b = 12'sd1; req0_c = 12'sd1;
    req0_valid = 1'b1;
    for (int k = 0; k < 70000; k++) step();
    req0_valid = 1'b0;
    step();
    n_cmp++;
    if (stat0 !== 16'hffff || stat1 !== 16'd0) begin
      n_err++;
      $display("FAIL stats_sat: got %0d/%0d want 65535/0", stat0, stat1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lone_req1();
    test_alternate();
    test_single();
    test_drain();
    test_reset_midflight();
`ifdef ABC_SCHED_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/abc_sched.md
ABC_SCHED -- requirements
Module: abc_sched

Interface
REQ-001 SHALL have parameter: LATENCY, 5, rising edges from dp_a/dp_b/dp_c update to valid dp_y.
REQ-002 SHALL have parameter: DW, 12, operand width; result width is 2*DW+1.
REQ-003 SHALL have port: clk  in  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port: rst_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports: req0_valid/req1_valid  in  1  each  operand set offered.
REQ-006 SHALL have ports: req0_ready/req1_ready  out  1  each  grant; combinational from state, pointer and valids.
REQ-007 SHALL have ports: req0_a/b/c, req1_a/b/c  in  DW  signed operands.
REQ-008 SHALL have ports: resp0_valid/resp1_valid  out  1  one-cycle result strobe.
REQ-009 SHALL have ports: resp0_y/resp1_y  out  2*DW+1  signed (a+b)*c.
REQ-010 SHALL have ports: dp_ce  out  1;  dp_a/dp_b/dp_c  out  DW;  dp_y  in  2*DW+1  (external abc datapath).
REQ-011 SHALL have ports: pause  in  1  drain request;  idle  out  1  no operation in flight and not issuing.

Function
REQ-012 A request SHALL be accepted on an edge where valid and ready are both 1; at most one acceptance per cycle.
REQ-013 Arbitration SHALL be round-robin: pointer names the preferred requester; after an acceptance it moves to the other requester; with no acceptance it holds.
REQ-014 With one valid requester, that requester SHALL be granted regardless of pointer.
REQ-015 On acceptance edge E0 the operands SHALL be registered into dp_a/dp_b/dp_c; with no acceptance dp_* SHALL hold.
REQ-016 A tag pipeline of LATENCY stages SHALL carry {valid, requester id}; a bubble enters on cycles without acceptance.
REQ-017 On edge E0+LATENCY+1, dp_y SHALL be registered into resp<id>_y and resp<id>_valid SHALL be 1 for exactly that cycle; total latency LATENCY+1 = 6 cycles at default.
REQ-018 resp_y of the non-addressed requester SHALL hold its last value; responses have no backpressure.
REQ-019 Back-to-back acceptances SHALL yield back-to-back responses in acceptance order.
REQ-020 States SHALL be RUN, DRAIN, IDLE. RUN: grants allowed. RUN->DRAIN when pause=1. DRAIN: no grants; ->IDLE when the tag pipeline holds no valid entry. IDLE: no grants; ->RUN when pause=0. DRAIN with pause=0 SHALL stay DRAIN until empty.
REQ-021 idle SHALL be 1 only in IDLE.
REQ-022 dp_ce SHALL be 1 in every cycle after reset release.

Reset
REQ-023 With rst_n=0 at an edge: state=RUN, pointer=requester 0, tag pipeline all invalid, dp_ce=0, dp_a/b/c=0, resp*_valid=0, resp*_y=0, idle=0.
REQ-024 Reset mid-operation SHALL discard all in-flight tags; no response SHALL be issued for them.

Configuration
REQ-025 With ABC_SCHED_STATS_EN defined, outputs stat0/stat1 (16 bits each) SHALL count acceptances per requester, saturating at 65535, cleared by reset.
REQ-026 Without ABC_SCHED_STATS_EN, stat0/stat1 and their counters SHALL be absent; all other behaviour is identical.

Structure
REQ-027 Package abc_pkg SHALL hold DW, result width, default LATENCY and the RUN/DRAIN/IDLE state encoding.
REQ-028 The tag pipeline SHALL be sub-module abc_sched_tagpipe (LATENCY deep, outputs tail entry and any-valid flag); the abc datapath is instantiated outside abc_sched.

Verification
REQ-029 Req0 a=4,b=6,c=7 alone -> resp0_valid 6 cycles after acceptance, resp0_y=70, resp1_valid stays 0.
REQ-030 Both valid every cycle, req0 (-4,26,23), req1 (2047,2047,-2048) -> grants alternate 0,1,0,1; responses alternate 506 and -8384512, back-to-back.
REQ-031 Req1 (-2048,-2048,-2048) with pointer at 0 and req0 idle -> immediate grant to req1, resp1_y=8388608.
REQ-032 Issue 3 operations, assert pause the next cycle -> no further ready, all 3 responses delivered, idle=1 one cycle after the pipeline empties; deassert pause -> RUN, grants resume.
REQ-033 rst_n=0 two cycles after an acceptance -> no response ever appears for it; all outputs at reset values.
REQ-034 With ABC_SCHED_STATS_EN, 70000 req0 acceptances -> stat0=65535, stat1=0.
